// File: rtl/wsg_pkg.sv
// Shared types and register-window offsets for the three-voice wavetable sound generator.
package wsg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    WAIT,
    MAC,
    DONE
  } state_t;

  typedef struct packed {
    logic [19:0] freq;
    logic [2:0]  wave_sel;
    logic [3:0]  vol;
  } voice_regs_t;

  localparam int NUM_VOICES = 3;

  localparam logic [4:0] OFF_WAVE0   = 5'h05;
  localparam logic [4:0] OFF_WAVE1   = 5'h0A;
  localparam logic [4:0] OFF_WAVE2   = 5'h0F;
  localparam logic [4:0] OFF_V0_FREQ = 5'h10;
  localparam logic [4:0] OFF_V0_VOL  = 5'h15;
  localparam logic [4:0] OFF_V1_FREQ = 5'h16;
  localparam logic [4:0] OFF_V1_VOL  = 5'h1A;
  localparam logic [4:0] OFF_V2_FREQ = 5'h1B;
  localparam logic [4:0] OFF_V2_VOL  = 5'h1F;

endpackage

// File: rtl/wsg_voice_sequencer_if.sv
// CPU write bus into the sound register window.
interface wsg_voice_sequencer_if;
  logic        wr_en;
  logic [15:0] ram_addr;
  logic [7:0]  cpu_data;

  modport master (output wr_en, output ram_addr, output cpu_data);
  modport slave  (input  wr_en, input  ram_addr, input  cpu_data);
endinterface

// File: rtl/wsg_voice_regs.sv
// Decodes CPU writes in the 32-byte sound window into per-voice frequency, waveform and volume.
module wsg_voice_regs
  import wsg_pkg::*;
#(
  parameter logic [15:0] ADDR_BASE = 16'h5040
) (
  input  logic                  clk,
  input  logic                  rst,
  wsg_voice_sequencer_if.slave  cpu,
  output voice_regs_t           v0_regs,
  output voice_regs_t           v1_regs,
  output voice_regs_t           v2_regs
);

  logic [16:0] rel;
  logic [4:0]  offset;
  logic [3:0]  nib;
  logic        in_win;
  logic        unused_hi;

  // A borrow into bit 16 means the address is below the window.
  assign rel       = {1'b0, cpu.ram_addr} - {1'b0, ADDR_BASE};
  assign in_win    = cpu.wr_en && (rel[16:5] == '0);
  assign offset    = rel[4:0];
  assign nib       = cpu.cpu_data[3:0];
  assign unused_hi = ^cpu.cpu_data[7:4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_regs <= '0;
      v1_regs <= '0;
      v2_regs <= '0;
    end else if (in_win) begin
      case (offset)
        OFF_WAVE0:   v0_regs.wave_sel     <= nib[2:0];
        OFF_WAVE1:   v1_regs.wave_sel     <= nib[2:0];
        OFF_WAVE2:   v2_regs.wave_sel     <= nib[2:0];
        5'h10:       v0_regs.freq[3:0]    <= nib;
        5'h11:       v0_regs.freq[7:4]    <= nib;
        5'h12:       v0_regs.freq[11:8]   <= nib;
        5'h13:       v0_regs.freq[15:12]  <= nib;
        5'h14:       v0_regs.freq[19:16]  <= nib;
        OFF_V0_VOL:  v0_regs.vol          <= nib;
        // Voices 1 and 2 have no low nibble; their freq[3:0] stays at reset value 0.
        5'h16:       v1_regs.freq[7:4]    <= nib;
        5'h17:       v1_regs.freq[11:8]   <= nib;
        5'h18:       v1_regs.freq[15:12]  <= nib;
        5'h19:       v1_regs.freq[19:16]  <= nib;
        OFF_V1_VOL:  v1_regs.vol          <= nib;
        5'h1B:       v2_regs.freq[7:4]    <= nib;
        5'h1C:       v2_regs.freq[11:8]   <= nib;
        5'h1D:       v2_regs.freq[15:12]  <= nib;
        5'h1E:       v2_regs.freq[19:16]  <= nib;
        OFF_V2_VOL:  v2_regs.vol          <= nib;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/wsg_voice_sequencer.sv
// Three-voice wavetable sequencer: per sample tick, steps each voice's phase accumulator,
// fetches its wave nibble from the shared ROM and accumulates the volume-scaled mix.
module wsg_voice_sequencer
  import wsg_pkg::*;
#(
  parameter logic [15:0] ADDR_BASE = 16'h5040,
  parameter int          ROM_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  wsg_voice_sequencer_if.slave  cpu,
  input  logic                  sample_tick,
  output logic [7:0]            wave_rom_addr,
  input  logic [3:0]            wave_rom_data,
  output logic [9:0]            sample_out,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  overrun
);

  if (ROM_LAT != 1) begin : g_lat_check
    $error("wsg_voice_sequencer supports only ROM_LAT == 1");
  end

  voice_regs_t v0_regs, v1_regs, v2_regs, cur;
  state_t      state, state_nxt;
  logic [1:0]  v;
  logic [9:0]  sum, sum_nxt;
  logic [19:0] acc [NUM_VOICES];
  logic [19:0] acc_cur, acc_nxt;

  function automatic logic [9:0] mac_step(input logic [9:0] s, input logic [3:0] d,
                                          input logic [3:0] g);
    logic [7:0] prod;
    prod = d * g;
    return s + {2'b00, prod};
  endfunction

  wsg_voice_regs #(.ADDR_BASE(ADDR_BASE)) u_regs (
    .clk     (clk),
    .rst     (rst),
    .cpu     (cpu),
    .v0_regs (v0_regs),
    .v1_regs (v1_regs),
    .v2_regs (v2_regs)
  );

  always_comb begin
    cur     = v2_regs;
    acc_cur = acc[2];
    case (v)
      2'd0: begin cur = v0_regs; acc_cur = acc[0]; end
      2'd1: begin cur = v1_regs; acc_cur = acc[1]; end
      default: ;
    endcase
  end

  assign acc_nxt = acc_cur + cur.freq;
  assign sum_nxt = mac_step(sum, wave_rom_data, cur.vol);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_tick) state_nxt = ACC;
      ACC:     state_nxt = WAIT;
      WAIT:    state_nxt = MAC;
      MAC:     state_nxt = (v == 2'd2) ? DONE : ACC;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: the mix result is registered on the last MAC so it is valid during DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v             <= '0;
      sum           <= '0;
      wave_rom_addr <= '0;
      sample_out    <= '0;
      sample_valid  <= 1'b0;
      overrun       <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) acc[i] <= '0;
    end else begin
      sample_valid <= 1'b0;
      if (sample_tick && busy) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            v   <= '0;
            sum <= '0;
          end
        end
        ACC: begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (v == 2'(i)) acc[i] <= acc_nxt;
          end
          wave_rom_addr <= {cur.wave_sel, acc_nxt[19:15]};
        end
        MAC: begin
          sum <= sum_nxt;
          if (v == 2'd2) begin
            sample_out   <= sum_nxt;
            sample_valid <= 1'b1;
          end else begin
            v <= v + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
